ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs) to the keyboard.
//  Frame: start(0), 8 data bits LSB-first, odd parity, stop(1), then the device ack bit.
//  Sits beside the PS/2 frame receiver. Drives open-drain enables to the top-level tristates.
//  Asserts rx_block while busy so the receiver ignores the frame it sends.
// PARAMETERS
//  INHIBIT_CYCLES  5000     sysclk cycles ps2_clk is held low before request-to-send (100 us @ 50 MHz)
//  TIMEOUT_CYCLES  750000   max sysclk cycles between device clock falling edges, or from RTS to first edge (15 ms)
// PORTS
//  clk          in   1  system clock; all logic on posedge
//  reset        in   1  reset, synchronous, active-low
//  tx_valid     in   1  request to send tx_data
//  tx_data      in   8  command byte; sampled on accept
//  tx_ready     out  1  high only in IDLE; a transfer is accepted when tx_valid & tx_ready
//  tx_done      out  1  1-cycle pulse; transfer finished and lines are idle
//  tx_nack      out  1  1-cycle pulse with tx_done when the ack bit was 1
//  tx_timeout   out  1  1-cycle pulse; watchdog expired and transfer aborted
//  rx_block     out  1  high in every state except IDLE
//  ps2_clk_in   in   1  raw PS/2 clock line (asynchronous)
//  ps2_data_in  in   1  raw PS/2 data line (asynchronous)
//  ps2_clk_oe   out  1  1 = pull PS/2 clock low; 0 = release
//  ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release
// BEHAVIOUR
//  - Sync: both ps2 inputs pass through 2 FFs. fall = prev_sync_clk & ~sync_clk (1-cycle strobe).
//  - Reset (reset==0 at posedge): state IDLE. Counters 0. Both oe 0. All pulses 0. tx_ready 1 after reset.
//  - IDLE: on accept, latch shreg = {1'b1, ~^tx_data, tx_data}. Set bitcnt=0, cnt=0. Go INHIBIT.
//  - INHIBIT: clk_oe=1. cnt counts to INHIBIT_CYCLES-1; data_oe=1 on the last cycle. Then go RTS with cnt=0.
//  - RTS: clk_oe=0, data_oe=1 (start bit). Device now clocks.
//    On each fall, present shreg[0] by setting data_oe=~bit, shift right, bitcnt++.
//    Falls 1..8 present data bits, fall 9 presents parity, fall 10 presents stop (data released).
//    After fall 10 go ACK.
//  - ACK: both oe 0. On the next fall, sample sync data: 1 -> nack flag. Go WAIT_IDLE.
//  - WAIT_IDLE: when sync clk and data are both 1, pulse tx_done (with tx_nack if flagged). Go IDLE.
//  - Watchdog: cnt clears on every fall and on state entry. It increments in RTS, ACK and WAIT_IDLE.
//    At cnt==TIMEOUT_CYCLES-1: both oe -> 0, pulse tx_timeout, go IDLE. No tx_done.
//  - Falls seen in IDLE or INHIBIT are ignored. tx_valid while busy is ignored, not queued.
//  - Timeout and fall in the same cycle: timeout wins.
//  - Reset mid-transfer: the next cycle has oe=0/0, state IDLE, no pulses.
//  - Throughput: one byte per transfer. Back-to-back accept is possible the cycle after tx_done.
// TESTING (bench: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=200, device model ps2 clk period 40 sysclk)
//  1. Send 0xED with device ack=0. Required: clk_oe held low 8 cycles; data bits 1,0,1,1,0,1,1,1; parity 1; stop 1.
//     Then tx_done=1, tx_nack=0, tx_ready=1 next cycle.
//  2. Send 0x01 with device ack=1. Required: parity bit 0; tx_done and tx_nack pulse together.
//  3. Send 0x55 with the device never clocking. Required: tx_timeout pulse 200 cycles into RTS; oe 0/0; no tx_done.
//  4. Hold tx_valid high with 0xF4 then 0x00 during a transfer. Required: the second byte is not accepted until after tx_done.
//     Two complete frames are sent.
//  5. Assert reset during bit 4 of 0xFF. Required: next cycle oe=0/0, tx_ready=1, no pulses. The next send of 0xAA is correct.
//  6. Stall the device clock for 250 cycles after fall 5. Required: tx_timeout pulses and lines are released.
//     rx_block stays high until that cycle.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then shifts one
// command byte out on device clock falls and collects the device acknowledge bit.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_nack,
  output logic       tx_timeout,
  output logic       rx_block,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAX_COUNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_COUNT) + 1;
  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INHIBIT_PRE  = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t        state;
  logic          clk_meta, clk_sync, clk_prev;
  logic          data_meta, data_sync;
  logic [9:0]    shreg;
  logic [3:0]    bitcnt;
  logic [CW-1:0] cnt;
  logic          nack_flag;
  logic          fall;

  assign fall     = clk_prev & ~clk_sync;
  assign tx_ready = (state == IDLE);
  assign rx_block = (state != IDLE);

  // One counter serves as the inhibit timer and as the watchdog between device clock falls;
  // the watchdog check comes first in each busy state so it wins over a coincident fall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      clk_meta    <= 1'b1;
      clk_sync    <= 1'b1;
      clk_prev    <= 1'b1;
      data_meta   <= 1'b1;
      data_sync   <= 1'b1;
      shreg       <= '0;
      bitcnt      <= '0;
      cnt         <= '0;
      nack_flag   <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_nack     <= 1'b0;
      tx_timeout  <= 1'b0;
    end else begin
      clk_meta   <= ps2_clk_in;
      clk_sync   <= clk_meta;
      clk_prev   <= clk_sync;
      data_meta  <= ps2_data_in;
      data_sync  <= data_meta;
      tx_done    <= 1'b0;
      tx_nack    <= 1'b0;
      tx_timeout <= 1'b0;

      unique case (state)
        IDLE: begin
          if (tx_valid) begin
            shreg       <= {1'b1, ~^tx_data, tx_data};
            bitcnt      <= '0;
            cnt         <= '0;
            nack_flag   <= 1'b0;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= (INHIBIT_CYCLES == 1);
            state       <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (cnt == INHIBIT_LAST) begin
            cnt         <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            state       <= RTS;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == INHIBIT_PRE) ps2_data_oe <= 1'b1;
          end
        end

        RTS: begin
          if (cnt == TIMEOUT_LAST) begin
            cnt         <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_timeout  <= 1'b1;
            state       <= IDLE;
          end else if (fall) begin
            // The stop bit is a 1, so presenting it also releases the data line before ACK.
            ps2_data_oe <= ~shreg[0];
            shreg       <= {1'b1, shreg[9:1]};
            bitcnt      <= bitcnt + 1'b1;
            cnt         <= '0;
            if (bitcnt == 4'd9) state <= ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ACK: begin
          if (cnt == TIMEOUT_LAST) begin
            cnt         <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_timeout  <= 1'b1;
            state       <= IDLE;
          end else if (fall) begin
            nack_flag <= data_sync;
            cnt       <= '0;
            state     <= WAIT_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_IDLE: begin
          if (cnt == TIMEOUT_LAST) begin
            cnt         <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_timeout  <= 1'b1;
            state       <= IDLE;
          end else if (clk_sync && data_sync) begin
            cnt     <= '0;
            tx_done <= 1'b1;
            tx_nack <= nack_flag;
            state   <= IDLE;
          end else if (fall) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a behavioural PS/2 keyboard clocks frames out of the host and
// every captured frame and status pulse is compared against an arithmetic frame model.
module tb_ps2_host_tx;

  localparam int INHIBIT = 8;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx_done, tx_nack, tx_timeout, rx_block;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk  = 1'b1;
  logic       dev_data = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cnt = 0;
  int done_cnt = 0;

  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_nack    (tx_nack),
    .tx_timeout (tx_timeout),
    .rx_block   (rx_block),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset && tx_valid && tx_ready) accept_cnt <= accept_cnt + 1;
  end

  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
  end

  // Expected line levels of a whole frame: index 0 start, 1..8 data LSB first, 9 odd parity, 10 stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      if (b[i]) ones++;
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input logic hold);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  // Keyboard model: waits for request-to-send, then generates n_falls clock pulses reading the
  // line while the clock is high; with 11 falls it also drives the acknowledge bit.
  task automatic device_xfer(input logic ack, input int n_falls,
                             output logic [10:0] bits, output logic got_rts, output int rts_cyc,
                             output int inh_len, output int inh_data_ones, output logic inh_last_data,
                             output int last_fall_cyc);
    bits = 'x;
    got_rts = 1'b0;
    rts_cyc = 0;
    inh_len = 0;
    inh_data_ones = 0;
    inh_last_data = 1'b0;
    last_fall_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ps2_clk_oe) begin
        inh_len++;
        if (ps2_data_oe) inh_data_ones++;
        inh_last_data = ps2_data_oe;
      end else if (ps2_data_oe) begin
        got_rts = 1'b1;
        rts_cyc = cyc;
        break;
      end
    end
    if (got_rts) begin
      repeat (10) @(negedge clk);
      bits[0] = ps2_data_in;
      for (int k = 1; k <= 10 && k <= n_falls; k++) begin
        dev_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        bits[k] = ps2_data_in;
      end
      if (n_falls >= 11) begin
        dev_data = ack;
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
      end
    end
  endtask

  task automatic wait_end(output logic saw_done, output logic saw_nack, output logic saw_timeout,
                          output logic prev_rx_block, output int at_cyc);
    saw_done = 1'b0;
    saw_nack = 1'b0;
    saw_timeout = 1'b0;
    prev_rx_block = rx_block;
    at_cyc = -1;
    for (int i = 0; i < 400; i++) begin
      prev_rx_block = rx_block;
      @(negedge clk);
      if (tx_done || tx_timeout) begin
        saw_done = tx_done;
        saw_nack = tx_nack;
        saw_timeout = tx_timeout;
        at_cyc = cyc;
        break;
      end
    end
  endtask

  logic [10:0] bits;
  logic        got_rts, inh_last, saw_done, saw_nack, saw_to, prev_rxb;
  int          rts_cyc, inh_len, inh_ones, fall_cyc, end_cyc, snap;

  task automatic full_transfer(input string tag, input logic [7:0] b, input logic ack);
    apply_stimulus(b, 1'b0);
    device_xfer(ack, 11, bits, got_rts, rts_cyc, inh_len, inh_ones, inh_last, fall_cyc);
    check_output({tag, " frame"}, 32'(bits), 32'(model_frame(b)));
    wait_end(saw_done, saw_nack, saw_to, prev_rxb, end_cyc);
    check_output({tag, " done"}, 32'(saw_done), 32'd1);
    check_output({tag, " nack"}, 32'(saw_nack), 32'(ack));
    check_output({tag, " timeout"}, 32'(saw_to), 32'd0);
    @(negedge clk);
    check_output({tag, " done_one_cycle"}, 32'(tx_done), 32'd0);
    check_output({tag, " ready_after"}, 32'(tx_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rack;

    reset    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_output("reset ready", 32'(tx_ready), 32'd1);
    check_output("reset oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check_output("reset rx_block", 32'(rx_block), 32'd0);
    check_output("reset pulses", 32'({tx_done, tx_nack, tx_timeout}), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] test 1: 0xED acked");
    apply_stimulus(8'hED, 1'b0);
    device_xfer(1'b0, 11, bits, got_rts, rts_cyc, inh_len, inh_ones, inh_last, fall_cyc);
    check_output("t1 rts", 32'(got_rts), 32'd1);
    check_output("t1 inhibit_len", 32'(inh_len), 32'(INHIBIT));
    check_output("t1 inhibit_data_ones", 32'(inh_ones), 32'd1);
    check_output("t1 inhibit_data_last", 32'(inh_last), 32'd1);
    check_output("t1 data_bits", 32'(bits[8:1]), 32'h0000_00ED);
    check_output("t1 parity", 32'(bits[9]), 32'd1);
    check_output("t1 frame", 32'(bits), 32'(model_frame(8'hED)));
    wait_end(saw_done, saw_nack, saw_to, prev_rxb, end_cyc);
    check_output("t1 done", 32'(saw_done), 32'd1);
    check_output("t1 nack", 32'(saw_nack), 32'd0);
    check_output("t1 ready_with_done", 32'(tx_ready), 32'd1);
    @(negedge clk);
    check_output("t1 ready_next", 32'(tx_ready), 32'd1);
    check_output("t1 done_one_cycle", 32'(tx_done), 32'd0);

    $display("[TB] test 2: 0x01 nacked");
    apply_stimulus(8'h01, 1'b0);
    device_xfer(1'b1, 11, bits, got_rts, rts_cyc, inh_len, inh_ones, inh_last, fall_cyc);
    check_output("t2 parity", 32'(bits[9]), 32'd0);
    check_output("t2 frame", 32'(bits), 32'(model_frame(8'h01)));
    wait_end(saw_done, saw_nack, saw_to, prev_rxb, end_cyc);
    check_output("t2 done", 32'(saw_done), 32'd1);
    check_output("t2 nack", 32'(saw_nack), 32'd1);

    $display("[TB] test 3: device silent");
    repeat (5) @(negedge clk);
    apply_stimulus(8'h55, 1'b0);
    device_xfer(1'b0, 0, bits, got_rts, rts_cyc, inh_len, inh_ones, inh_last, fall_cyc);
    check_output("t3 rts", 32'(got_rts), 32'd1);
    wait_end(saw_done, saw_nack, saw_to, prev_rxb, end_cyc);
    check_output("t3 timeout", 32'(saw_to), 32'd1);
    check_output("t3 no_done", 32'(saw_done), 32'd0);
    check_output("t3 timeout_delay", 32'(end_cyc - rts_cyc), 32'(TIMEOUT));
    check_output("t3 oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    snap = done_cnt;
    repeat (50) @(negedge clk);
    check_output("t3 no_late_done", 32'(done_cnt - snap), 32'd0);

    $display("[TB] test 4: tx_valid held across a transfer");
    apply_stimulus(8'hF4, 1'b1);
    tx_data = 8'h00;
    device_xfer(1'b0, 11, bits, got_rts, rts_cyc, inh_len, inh_ones, inh_last, fall_cyc);
    check_output("t4 first_frame", 32'(bits), 32'(model_frame(8'hF4)));
    check_output("t4 busy_ignored", 32'(accept_cnt), 32'd4);
    wait_end(saw_done, saw_nack, saw_to, prev_rxb, end_cyc);
    check_output("t4 first_done", 32'(saw_done), 32'd1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    check_output("t4 second_accept", 32'(accept_cnt), 32'd5);
    device_xfer(1'b0, 11, bits, got_rts, rts_cyc, inh_len, inh_ones, inh_last, fall_cyc);
    check_output("t4 second_frame", 32'(bits), 32'(model_frame(8'h00)));
    wait_end(saw_done, saw_nack, saw_to, prev_rxb, end_cyc);
    check_output("t4 second_done", 32'(saw_done), 32'd1);
    repeat (60) @(negedge clk);
    check_output("t4 only_two", 32'(accept_cnt), 32'd5);

    $display("[TB] test 5: reset mid-frame");
    apply_stimulus(8'hFF, 1'b0);
    device_xfer(1'b0, 4, bits, got_rts, rts_cyc, inh_len, inh_ones, inh_last, fall_cyc);
    check_output("t5 busy_before", 32'(rx_block), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check_output("t5 oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check_output("t5 ready", 32'(tx_ready), 32'd1);
    check_output("t5 pulses", 32'({tx_done, tx_nack, tx_timeout}), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    full_transfer("t5 after_reset", 8'hAA, 1'b0);

    $display("[TB] test 6: device stalls after fall 5");
    apply_stimulus(8'h3C, 1'b0);
    device_xfer(1'b0, 5, bits, got_rts, rts_cyc, inh_len, inh_ones, inh_last, fall_cyc);
    check_output("t6 data_bits", 32'(bits[5:1]), 32'(model_frame(8'h3C) >> 1) & 32'h1F);
    wait_end(saw_done, saw_nack, saw_to, prev_rxb, end_cyc);
    check_output("t6 timeout", 32'(saw_to), 32'd1);
    check_output("t6 no_done", 32'(saw_done), 32'd0);
    check_output("t6 delay_window", 32'((end_cyc - fall_cyc >= 195) && (end_cyc - fall_cyc <= 210)), 32'd1);
    check_output("t6 oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check_output("t6 rx_block_before", 32'(prev_rxb), 32'd1);
    check_output("t6 rx_block_at", 32'(rx_block), 32'd0);
    repeat (50) @(negedge clk);

    $display("[TB] random transfers");
    for (int n = 0; n < 4; n++) begin
      rb   = 8'($urandom_range(0, 255));
      rack = 1'($urandom_range(0, 1));
      full_transfer($sformatf("rand%0d_%02h", n, rb), rb, rack);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
